dmem_arbiter: RTL and testbench

//  Shares the single-ported data memory between two requesters: the CPU MEM stage (port cpu) and the

---
 rtl/dmem_arbiter_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 19 +
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM state codes
// and the alignment rule applied to every request before it reaches memory.
package dmem_arbiter_pkg;

  localparam logic [2:0] LEN_BYTE = 3'b001;
  localparam logic [2:0] LEN_HALF = 3'b010;
  localparam logic [2:0] LEN_WORD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Unknown sizes and naturally misaligned halves/words never touch memory.
  function automatic logic access_illegal(input logic [2:0] len, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (len)
      LEN_BYTE: bad = 1'b0;
      LEN_HALF: bad = addr_lo[0];
      LEN_WORD: bad = (addr_lo != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a sole requester wins outright, a tie goes to the
// port that did not win last time. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant[0] ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage and the debug
// port: round-robin grant, req/ack handshake, wait states and alignment checks.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [2:0]    cpu_len_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic          cpu_err_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,

  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [2:0]    dbg_len_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic          dbg_ack_o,
  output logic          dbg_err_o,
  output logic [DW-1:0] dbg_rdata_o,

  output logic          mem_we_o,
  output logic [2:0]    mem_len_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,

  output logic [1:0]    grant_o
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          owner_dbg;
  logic [1:0]    last_grant;

  logic          lat_we;
  logic [2:0]    lat_len;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dbg_rdata_q;
  logic          cpu_err_q;
  logic          dbg_err_q;

  logic [1:0]    gnt;
  logic          sel_we;
  logic [2:0]    sel_len;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_illegal;
  logic          take;
  logic          final_access;

  rr_arb2 u_rr (
    .req        ({dbg_req_i, cpu_req_i}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign sel_we      = gnt[1] ? dbg_we_i    : cpu_we_i;
  assign sel_len     = gnt[1] ? dbg_len_i   : cpu_len_i;
  assign sel_addr    = gnt[1] ? dbg_addr_i  : cpu_addr_i;
  assign sel_wdata   = gnt[1] ? dbg_wdata_i : cpu_wdata_i;
  assign sel_illegal = access_illegal(sel_len, sel_addr[1:0]);

  // Requests are only looked at in IDLE, so a req held through DONE counts as a new one.
  assign take         = (state == S_IDLE) && (gnt != 2'b00);
  assign final_access = (state == S_ACCESS) && (wait_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_we_o    = 1'b0;
    mem_len_o   = lat_len;
    mem_addr_o  = lat_addr;
    mem_wdata_o = lat_wdata;
    grant_o     = 2'b00;
    cpu_ack_o   = 1'b0;
    dbg_ack_o   = 1'b0;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_nxt = sel_illegal ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        grant_o  = owner_dbg ? 2'b10 : 2'b01;
        mem_we_o = final_access & lat_we;
        if (final_access) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        grant_o   = owner_dbg ? 2'b10 : 2'b01;
        cpu_ack_o = ~owner_dbg;
        dbg_ack_o = owner_dbg;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      owner_dbg   <= 1'b0;
      last_grant  <= 2'b10;
      lat_we      <= 1'b0;
      lat_len     <= 3'b000;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_err_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
    end else begin
      if (take) begin
        lat_we     <= sel_we;
        lat_len    <= sel_len;
        lat_addr   <= sel_addr;
        lat_wdata  <= sel_wdata;
        owner_dbg  <= gnt[1];
        last_grant <= gnt;
        wait_cnt   <= CW'(WAIT_CYCLES);
        if (gnt[1]) begin
          dbg_err_q <= sel_illegal;
        end else begin
          cpu_err_q <= sel_illegal;
        end
      end
      if (state == S_ACCESS) begin
        if (wait_cnt != '0) begin
          wait_cnt <= wait_cnt - 1'b1;
        end else if (!lat_we) begin
          if (owner_dbg) begin
            dbg_rdata_q <= mem_rdata_i;
          end else begin
            cpu_rdata_q <= mem_rdata_i;
          end
        end
      end
    end
  end

  assign cpu_rdata_o = cpu_rdata_q;
  assign dbg_rdata_o = dbg_rdata_q;
  assign cpu_err_o   = cpu_err_q;
  assign dbg_err_o   = dbg_err_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (0 and 3 wait states), each with its own
// memory, cycle-counting reference model, per-cycle compare and directed tests.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input int ln, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL lane%0d %s actual=%h required=%h t=%0t", ln, nm, act, exp, $time);
    end
  endtask

  function automatic logic bad_access(input logic [2:0] len, input logic [1:0] lo);
    if (len == 3'b001) return 1'b0;
    if (len == 3'b010) return lo[0];
    if (len == 3'b100) return lo != 2'b00;
    return 1'b1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] len, input logic [1:0] lo);
    logic [31:0] m;
    if (len == 3'b100) m = 32'hFFFF_FFFF;
    else if (len == 3'b010) m = 32'h0000_FFFF << (8 * lo);
    else m = 32'h0000_00FF << (8 * lo);
    return (old & ~m) | ((wd << (8 * lo)) & m);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = 3 * g;

    logic rst = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [2:0] cpu_len = 3'b100, dbg_len = 3'b100;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, mem_we;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0] mem_len;
    logic [1:0] grant;
    logic [31:0] mem [64];
    logic done = 1'b0;

    dmem_arbiter #(.WAIT_CYCLES(W), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_len_i(cpu_len), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_rdata_o(cpu_rdata),
      .cpu_stall_o(cpu_stall),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_len_i(dbg_len), .dbg_addr_i(dbg_addr),
      .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_err_o(dbg_err), .dbg_rdata_o(dbg_rdata),
      .mem_we_o(mem_we), .mem_len_o(mem_len), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .grant_o(grant)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
      if (!rst && mem_we) mem[mem_addr[7:2]] = merge(mem[mem_addr[7:2]], mem_wdata, mem_len, mem_addr[1:0]);
    end

    // Model: m_t counts cycles since the grant; the ack cycle is t = W+1 (t = 0 on error).
    logic m_busy = 1'b0, m_dbg = 1'b0, m_err = 1'b0, m_we = 1'b0, m_last_dbg = 1'b1;
    int m_t = 0, m_ack_t = 0;
    logic [31:0] m_addr = '0;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy = 1'b0;
        m_last_dbg = 1'b1;
      end else if (m_busy) begin
        if (m_t == m_ack_t) m_busy = 1'b0;
        else m_t++;
      end else if (cpu_req || dbg_req) begin
        m_dbg = dbg_req && (!cpu_req || !m_last_dbg);
        m_last_dbg = m_dbg;
        m_we = m_dbg ? dbg_we : cpu_we;
        m_addr = m_dbg ? dbg_addr : cpu_addr;
        m_err = bad_access(m_dbg ? dbg_len : cpu_len, m_addr[1:0]);
        m_ack_t = m_err ? 0 : W + 1;
        m_t = 0;
        m_busy = 1'b1;
      end
    end

    always @(negedge clk) begin
      logic e_ack;
      e_ack = m_busy && (m_t == m_ack_t);
      chk(g, "cpu_ack", cpu_ack, e_ack && !m_dbg);
      chk(g, "dbg_ack", dbg_ack, e_ack && m_dbg);
      chk(g, "grant", grant, m_busy ? (m_dbg ? 2'b10 : 2'b01) : 2'b00);
      chk(g, "mem_we", mem_we, m_busy && !m_err && m_we && (m_t == W));
      chk(g, "cpu_stall", cpu_stall, cpu_req && !(e_ack && !m_dbg));
      if (m_busy && !m_err) chk(g, "mem_addr", mem_addr, m_addr);
      if (e_ack) begin
        chk(g, "err", m_dbg ? dbg_err : cpu_err, m_err);
        if (!m_err && !m_we) chk(g, "rdata", m_dbg ? dbg_rdata : cpu_rdata, mem[m_addr[7:2]]);
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
    endtask

    // Issue one CPU command and run it to its ack, recording latency and pulses.
    task automatic cpu_run(input logic we, input logic [2:0] len, input logic [31:0] addr,
                           input logic [31:0] wd, output int k, output int n_stall,
                           output int n_we, output int we_at);
      cpu_req = 1'b1; cpu_we = we; cpu_len = len; cpu_addr = addr; cpu_wdata = wd;
      k = 0; n_we = 0; we_at = -1;
      #1;
      n_stall = int'(cpu_stall);
      while (k < 40) begin
        step();
        k++;
        if (mem_we) begin n_we++; we_at = k; end
        if (cpu_ack) break;
        n_stall += int'(cpu_stall);
      end
      if (!cpu_ack) chk(g, "ack_timeout", 32'd0, 32'd1);
      cpu_req = 1'b0;
    endtask

    initial begin
      int k, ns, nw, wa, nc, nd, na, k1, k2;
      int ord [4];
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[4] = 32'hDEAD_BEEF;
      do_reset();
      chk(g, "rst_mem_addr", mem_addr, 32'h0);
      chk(g, "rst_cpu_rdata", cpu_rdata, 32'h0);
      chk(g, "rst_grant", grant, 32'h0);

      // 1: plain read
      cpu_run(1'b0, 3'b100, 32'h10, 32'h0, k, ns, nw, wa);
      chk(g, "t1_latency", k, W + 2);
      chk(g, "t1_stall_cycles", ns, W + 2);
      chk(g, "t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
      step();

      // 2: write, single write pulse in the last access cycle, then read back
      cpu_run(1'b1, 3'b100, 32'h20, 32'hCAFE_F00D, k, ns, nw, wa);
      chk(g, "t2_latency", k, W + 2);
      chk(g, "t2_we_count", nw, 1);
      chk(g, "t2_we_at", wa, W + 1);
      chk(g, "t2_mem", mem[8], 32'hCAFE_F00D);
      step();
      cpu_run(1'b0, 3'b100, 32'h20, 32'h0, k, ns, nw, wa);
      chk(g, "t2_readback", cpu_rdata, 32'hCAFE_F00D);

      // 3: both ports requesting from reset alternate strictly
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_len = 3'b100; cpu_addr = 32'h0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_len = 3'b100; dbg_addr = 32'h4;
      nc = 0; nd = 0; na = 0;
      for (int i = 0; i < 80 && na < 4; i++) begin
        step();
        if (cpu_ack) begin ord[na] = 0; na++; nc++; if (nc == 2) cpu_req = 1'b0; end
        if (dbg_ack && na < 4) begin ord[na] = 1; na++; nd++; if (nd == 2) dbg_req = 1'b0; end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      chk(g, "t3_ack_count", na, 4);
      for (int i = 0; i < 4; i++) chk(g, "t3_order", (na > i) ? ord[i] : -1, i % 2);
      step();

      // 4: misaligned and illegal sizes end in an error ack with no memory access
      cpu_run(1'b1, 3'b100, 32'h22, 32'h0000_0BAD, k, ns, nw, wa);
      chk(g, "t4_latency", k, 1);
      chk(g, "t4_err", cpu_err, 1);
      chk(g, "t4_no_we", nw, 0);
      chk(g, "t4_mem_kept", mem[8], 32'hCAFE_F00D);
      step();
      cpu_run(1'b0, 3'b011, 32'h0, 32'h0, k, ns, nw, wa);
      chk(g, "t4_len011_err", cpu_err, 1);
      chk(g, "t4_len011_latency", k, 1);
      step();
      cpu_run(1'b0, 3'b010, 32'h22, 32'h0, k, ns, nw, wa);
      chk(g, "t4_half_ok_err", cpu_err, 0);
      chk(g, "t4_half_ok_latency", k, W + 2);
      step();

      // 5: reset in the final access cycle of a write suppresses the write and the ack
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_len = 3'b100; cpu_addr = 32'h30; cpu_wdata = 32'h1234_5678;
      for (int i = 0; i <= W; i++) step();
      chk(g, "t5_we_before_rst", mem_we, 1);
      rst = 1'b1;
      cpu_req = 1'b0;
      #1;
      chk(g, "t5_we_at_rst", mem_we, 0);
      chk(g, "t5_grant_at_rst", grant, 0);
      step();
      rst = 1'b0;
      na = 0;
      for (int i = 0; i < 6; i++) begin step(); na += int'(cpu_ack); end
      chk(g, "t5_no_ack", na, 0);
      chk(g, "t5_mem_unchanged", mem[12], 32'h0);

      // 6: back-to-back reads with req held high
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_len = 3'b100; cpu_addr = 32'h0;
      k1 = -1; k2 = -1;
      for (int i = 1; i < 60 && k2 < 0; i++) begin
        step();
        if (cpu_ack && k1 < 0) begin
          k1 = i;
          chk(g, "t6_rdata0", cpu_rdata, 32'h1111_1111);
          cpu_addr = 32'h4;
        end else if (cpu_ack) begin
          k2 = i;
          chk(g, "t6_rdata1", cpu_rdata, 32'h2222_2222);
        end
      end
      cpu_req = 1'b0;
      chk(g, "t6_ack_spacing", k2 - k1, W + 3);
      step();
      step();
      done = 1'b1;
    end
  end

  initial begin
    int i;
    for (i = 0; i < 5000; i++) begin
      if (lane[0].done && lane[1].done) break;
      @(posedge clk);
    end
    n_cmp++;
    if (!(lane[0].done && lane[1].done)) begin
      n_bad++;
      $display("FAIL timeout actual=not_done required=done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
